// File: rtl/alu_button_sequencer.sv
// Button front end for the ALU board: synchronize and debounce add/sub, latch operand
// addresses, issue one ALU operation per press. Define ALU_SEQ_REPEAT_EN for auto-repeat.
module alu_button_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] ra_sw,
    input  logic [3:0] rb_sw,
    input  logic       add_button,
    input  logic       sub_button,
    output logic [3:0] ra,
    output logic [3:0] rb,
    output logic [7:0] opcode,
    output logic       regwrt,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam logic [7:0]  OPC_ADD  = 8'h05;
    localparam logic [7:0]  OPC_SUB  = 8'h09;
    localparam logic [7:0]  OPC_IDLE = 8'h00;
    localparam logic [25:0] DB_LAST  = 26'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 67108863 ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES > 67108863) begin : g_bad_param
        $error("alu_button_sequencer: cycle parameters must lie in 1..2^26-1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    typedef enum logic {OP_ADD, OP_SUB} op_sel_t;

    // Bit 0 tracks the add button, bit 1 the sub button; all levels are active-low.
    logic [1:0]  sync1, sync2, db, db_d;
    logic [25:0] db_cnt [2];
    logic [1:0]  press;
    logic        released;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours regardless of statement order.
    // The two-entry counter array is ordinary control state and is reset like any flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            db    <= 2'b11;
            db_d  <= 2'b11;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {sub_button, add_button};
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 26'd1;
                end
            end
        end
    end

    assign press    = db_d & ~db;
    assign released = &db;

    state_t  state, state_next;
    op_sel_t op_sel, op_sel_next;
    logic    latch_sw;
    logic    count_inc;

`ifdef ALU_SEQ_REPEAT_EN
    localparam logic [25:0] RPT_LAST = 26'(REPEAT_CYCLES - 1);
    logic [25:0] rpt_cnt;
    logic        sel_held;

    assign sel_held = (op_sel == OP_ADD) ? !db[0] : !db[1];

    // Counts only while HOLD persists; any entry into HOLD starts from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_cnt <= '0;
        end else if (state == HOLD && state_next == HOLD) begin
            rpt_cnt <= rpt_cnt + 26'd1;
        end else begin
            rpt_cnt <= '0;
        end
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        op_sel_next = op_sel;
        latch_sw    = 1'b0;
        count_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (press != 2'b00) begin
                    state_next  = ISSUE;
                    op_sel_next = press[0] ? OP_ADD : OP_SUB;
                    latch_sw    = 1'b1;
                end
            end
            ISSUE: begin
                state_next = HOLD;
                count_inc  = 1'b1;
            end
            HOLD: begin
                if (released) begin
                    state_next = IDLE;
`ifdef ALU_SEQ_REPEAT_EN
                end else if (rpt_cnt == RPT_LAST && sel_held) begin
                    state_next = ISSUE;
                    latch_sw   = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_sel   <= OP_ADD;
            ra       <= '0;
            rb       <= '0;
            opcode   <= OPC_IDLE;
            regwrt   <= 1'b0;
            busy     <= 1'b0;
            op_count <= '0;
        end else begin
            state    <= state_next;
            op_sel   <= op_sel_next;
            regwrt   <= (state_next == ISSUE);
            busy     <= (state_next != IDLE);
            op_count <= op_count + 8'(count_inc);
            if (state_next == IDLE) begin
                opcode <= OPC_IDLE;
            end else begin
                opcode <= (op_sel_next == OP_ADD) ? OPC_ADD : OPC_SUB;
            end
            if (latch_sw) begin
                ra <= ra_sw;
                rb <= rb_sw;
            end
        end
    end

endmodule

// File: tb/tb_alu_button_sequencer.sv
// Scoreboard bench for alu_button_sequencer: stimulus pushes each expected issue,
// a negedge monitor pops and compares on every regwrt pulse.
module tb_alu_button_sequencer;

    localparam int DB  = 4;
    localparam int RPT = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] ra_sw, rb_sw;
    logic       add_button, sub_button;
    logic [3:0] ra, rb;
    logic [7:0] opcode;
    logic       regwrt, busy;
    logic [7:0] op_count;

    alu_button_sequencer #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RPT)) dut (
        .clock      (clock),
        .reset      (reset),
        .ra_sw      (ra_sw),
        .rb_sw      (rb_sw),
        .add_button (add_button),
        .sub_button (sub_button),
        .ra         (ra),
        .rb         (rb),
        .opcode     (opcode),
        .regwrt     (regwrt),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] opc;
        logic [7:0] count;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         vectors = 0;
    int         errors = 0;
    logic [7:0] exp_count = 8'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] opc, input int at);
        sb.push_back('{ra: ra_sw, rb: rb_sw, opc: opc, count: exp_count, cyc: at});
        exp_count++;
    endtask

    // Issue lands DB+3 negedges after the negedge on which the button is driven low.
    task automatic press(input logic a, input logic s, input int hold, input int settle);
        push_exp(a ? 8'h05 : 8'h09, cyc + DB + 3);
        add_button = ~a;
        sub_button = ~s;
        repeat (hold) @(negedge clock);
        check("busy_held", busy, 1);
        check("regwrt_single", regwrt, 0);
        check("op_count_held", op_count, exp_count);
        add_button = 1'b1;
        sub_button = 1'b1;
        repeat (settle) @(negedge clock);
        check("busy_released", busy, 0);
        check("opcode_idle", opcode, 8'h00);
    endtask

    exp_t e;
    always @(negedge clock) begin
        if (reset === 1'b1 && regwrt === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_regwrt: got regwrt=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("issue_cycle", cyc, e.cyc);
                check("issue_ra", ra, e.ra);
                check("issue_rb", rb, e.rb);
                check("issue_opcode", opcode, e.opc);
                check("issue_op_count", op_count, e.count);
                check("issue_busy", busy, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r;
        reset = 1'b0;
        add_button = 1'b1;
        sub_button = 1'b1;
        ra_sw = 4'd7;
        rb_sw = 4'd7;
        repeat (3) @(negedge clock);
        check("rst_ra", ra, 0);
        check("rst_rb", rb, 0);
        check("rst_opcode", opcode, 8'h00);
        check("rst_regwrt", regwrt, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Basic add press
        ra_sw = 4'd3;
        rb_sw = 4'd5;
        press(1'b1, 1'b0, 9, 8);

        // Short sub glitch must not issue
        sub_button = 1'b0;
        repeat (3) @(negedge clock);
        sub_button = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("glitch_busy", busy, 0);
            check("glitch_opcode", opcode, 8'h00);
        end

        // Simultaneous press: add wins
        ra_sw = 4'd1;
        rb_sw = 4'd2;
        press(1'b1, 1'b1, 9, 8);

`ifndef ALU_SEQ_REPEAT_EN
        // Both fall together, then sub re-pressed while add stays held
        push_exp(8'h05, cyc + DB + 3);
        add_button = 1'b0;
        sub_button = 1'b0;
        repeat (9) @(negedge clock);
        sub_button = 1'b1;
        repeat (10) @(negedge clock);
        sub_button = 1'b0;
        repeat (12) @(negedge clock);
        check("hold_busy", busy, 1);
        check("hold_opcode", opcode, 8'h05);
        add_button = 1'b1;
        sub_button = 1'b1;
        repeat (17) @(negedge clock);
        check("hold_release_busy", busy, 0);
`endif

        // Switch motion during HOLD is ignored
        ra_sw = 4'd3;
        rb_sw = 4'd5;
        push_exp(8'h05, cyc + DB + 3);
        add_button = 1'b0;
        repeat (8) @(negedge clock);
        ra_sw = 4'd9;
        @(negedge clock);
        check("hold_ra", ra, 3);
        add_button = 1'b1;
        repeat (8) @(negedge clock);
        check("hold_ra_idle", ra, 3);
        press(1'b0, 1'b1, 9, 8);
        check("sub_ra", ra, 9);

        // Reset one cycle after ISSUE, button held through reset release
        c = cyc;
        push_exp(8'h05, c + DB + 3);
        add_button = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_ra", ra, 0);
        check("mid_rst_rb", rb, 0);
        check("mid_rst_opcode", opcode, 8'h00);
        check("mid_rst_regwrt", regwrt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_op_count", op_count, 0);
        exp_count = 8'd0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        r = cyc;
        push_exp(8'h05, r + DB + 3);
        repeat (9) @(negedge clock);
        check("post_rst_op_count", op_count, 1);
        add_button = 1'b1;
        repeat (8) @(negedge clock);
        check("post_rst_busy", busy, 0);

`ifdef ALU_SEQ_REPEAT_EN
        // Auto-repeat: held add re-issues every RPT+1 cycles
        ra_sw = 4'd4;
        rb_sw = 4'd6;
        c = cyc;
        for (int k = 0; k < 5; k++) push_exp(8'h05, c + DB + 3 + k * (RPT + 1));
        add_button = 1'b0;
        repeat (DB + 3 + 40) @(negedge clock);
        add_button = 1'b1;
        repeat (20) @(negedge clock);
        check("repeat_busy", busy, 0);
        check("repeat_op_count", op_count, exp_count);
`endif

        // Drive op_count around its wrap point
        while (exp_count != 8'd0) begin
            ra_sw = exp_count[3:0];
            rb_sw = exp_count[7:4];
            press(exp_count[0], ~exp_count[0], 9, 8);
        end
        check("wrap_op_count", op_count, 8'd0);
        press(1'b1, 1'b0, 9, 8);
        check("after_wrap_op_count", op_count, 8'd1);

        repeat (4) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
